load_store_unit: RTL and testbench

Memory-side initiator that drives the `data_memory` block's `mem_write`/`mem_read`/`address`/`write_data`/`read_data` port set. It accepts one load or store request at a time from the datapath over a valid/ready handshake. It performs doubleword-aligned accesses, using read-modify-write for sub-doubleword stores because `data_memory` writes only full 64-bit words. It returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
//
// Memory-side initiator for the data_memory block. Accepts one load or store
// at a time, issues doubleword-aligned accesses, performs read-modify-write
// for sub-doubleword stores and returns sign/zero-extended load data.
//
// Handshake: a request transfers on a rising clock edge where
// req_valid && req_ready; req_ready is high only in IDLE. The response is a
// single-cycle resp_valid pulse with no back-pressure.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   req_valid/ready     request handshake
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 doubleword
//   req_signed          sign-extend loads (ignored for doubleword)
//   req_address         byte address
//   req_wdata           store data, low-order bytes
//   resp_valid          one-cycle response pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          misaligned request
//   mem_*               data_memory port set
//   dbg_state           current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [63:0]           mem_write_data,
    input  logic [63:0]           mem_read_data,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured at the accept edge.
    logic       r_write;
    logic [1:0] r_size;
    logic       r_signed;
    logic [2:0] r_offset;

    logic        accept;
    logic        misaligned;
    logic [63:0] ld_shift;
    logic [63:0] ld_ext;
    logic [7:0]  lane_base;
    logic [7:0]  lane_mask;
    logic [63:0] wd_shift;
    logic [63:0] merged;

    assign dbg_state = state;
    assign accept    = req_valid && (state == IDLE);

    // Natural alignment check on the incoming request.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_address[0];
            2'b10:   misaligned = |req_address[1:0];
            2'b11:   misaligned = |req_address[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)
                        state_next = RESP;
                    else if (req_write && req_size == 2'b11)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                mem_read   = 1'b1;
                state_next = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_write  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load extraction: bring the addressed byte to lane 0, then extend.
    always_comb begin
        ld_shift = mem_read_data >> {r_offset, 3'b000};
        ld_ext   = ld_shift;
        case (r_size)
            2'b00:   ld_ext = {{56{r_signed & ld_shift[7]}},  ld_shift[7:0]};
            2'b01:   ld_ext = {{48{r_signed & ld_shift[15]}}, ld_shift[15:0]};
            2'b10:   ld_ext = {{32{r_signed & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Store merge: mem_write_data holds the raw store data during READ;
    // the addressed lanes take the shifted store data, the rest keep the
    // old memory contents. Alignment guarantees the mask never wraps.
    always_comb begin
        case (r_size)
            2'b00:   lane_base = 8'h01;
            2'b01:   lane_base = 8'h03;
            2'b10:   lane_base = 8'h0F;
            default: lane_base = 8'hFF;
        endcase
        lane_mask = lane_base << r_offset;
        wd_shift  = mem_write_data << {r_offset, 3'b000};
        merged    = '0;
        for (int k = 0; k < 8; k++) begin
            merged[8*k +: 8] = lane_mask[k] ? wd_shift[8*k +: 8]
                                            : mem_read_data[8*k +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_signed       <= 1'b0;
            r_offset       <= 3'b000;
            mem_address    <= '0;
            mem_write_data <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_offset    <= req_address[2:0];
                        mem_address <= {req_address[ADDR_WIDTH-1:3], 3'b000};
                        if (misaligned) begin
                            resp_rdata <= '0;
                            resp_error <= 1'b1;
                        end else if (req_write) begin
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                READ: begin
                    if (r_write) begin
                        mem_write_data <= merged;
                    end else begin
                        resp_rdata <= ld_ext;
                        resp_error <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_address = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;
    logic [1:0]  dbg_state;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .dbg_state(dbg_state)
    );

    // data_memory stand-in: combinational read, write on rising edge.
    logic [63:0] mem [0:15] = '{default: 64'h0};
    assign mem_read_data = mem_read ? mem[mem_address[6:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
    always @(posedge clock) if (mem_write) mem[mem_address[6:3]] <= mem_write_data;

    // ---------------- counters / check ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [0:15] = '{default: 64'h0};

    function automatic logic [63:0] mdl_load(input logic [63:0] word, input int off,
                                             input int nb, input logic sg);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (sg && nb < 8 && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [63:0] mdl_store(input logic [63:0] word, input int off,
                                              input int nb, input logic [63:0] wd);
        logic [63:0] v;
        v = word;
        for (int i = 0; i < nb; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    // ---------------- scoreboard / compare ----------------
    logic [64:0] exp_q[$];      // {error, rdata}
    logic        busy = 1'b0;
    int          t0 = 0;
    int          ex_kind = 0;   // 0 error, 1 load, 2 dword store, 3 sub-dword store
    int          ex_lat = 0;
    int          ex_idx = 0;
    logic [63:0] ex_wword = '0;
    logic [31:0] ex_addr = '0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [63:0] last_mwd = '0;
    logic [63:0] last_exp = '0;

    always @(negedge clock) begin : compare
        int k, nb, off;
        logic e_rd, e_wr, e_rv;
        logic [64:0] e;
        if (!reset_n) begin
            check("rst_req_ready", {63'h0, req_ready}, 64'h1);
            check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
            check("rst_resp_rdata", resp_rdata, 64'h0);
            check("rst_resp_error", {63'h0, resp_error}, 64'h0);
            check("rst_mem_write", {63'h0, mem_write}, 64'h0);
            check("rst_mem_read", {63'h0, mem_read}, 64'h0);
            check("rst_mem_address", {32'h0, mem_address}, 64'h0);
            check("rst_mem_wdata", mem_write_data, 64'h0);
            busy = 1'b0;
            exp_q.delete();
        end else begin
            e_rd = 1'b0; e_wr = 1'b0; e_rv = 1'b0;
            if (busy) begin
                k = cyc - t0;
                e_rd = (ex_kind == 1 || ex_kind == 3) && k == 1;
                e_wr = (ex_kind == 2 && k == 1) || (ex_kind == 3 && k == 2);
                e_rv = (k == ex_lat);
            end
            check("req_ready", {63'h0, req_ready}, {63'h0, !busy});
            check("mem_read", {63'h0, mem_read}, {63'h0, e_rd});
            check("mem_write", {63'h0, mem_write}, {63'h0, e_wr});
            check("resp_valid", {63'h0, resp_valid}, {63'h0, e_rv});
            if (e_rd || e_wr) check("mem_address", {32'h0, mem_address}, {32'h0, ex_addr});
            if (e_wr) begin
                check("mem_write_data", mem_write_data, ex_wword);
                last_mwd = mem_write_data;
            end
            if (e_rv) begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e[63:0]);
                check("resp_error", {63'h0, resp_error}, {63'h0, e[64]});
                last_rdata = resp_rdata;
                last_err = resp_error;
                if (ex_kind >= 2) ref_mem[ex_idx] = ex_wword;
                busy = 1'b0;
            end
            if (!busy && req_valid && req_ready) begin
                nb = 1 << req_size;
                off = int'(req_address[2:0]);
                ex_idx = int'(req_address[6:3]);
                ex_addr = {req_address[31:3], 3'b000};
                if ((req_address % nb) != 0) begin
                    ex_kind = 0; ex_lat = 1;
                    exp_q.push_back({1'b1, 64'h0});
                    last_exp = 64'h0;
                end else if (!req_write) begin
                    ex_kind = 1; ex_lat = 2;
                    last_exp = mdl_load(ref_mem[ex_idx], off, nb, req_signed);
                    exp_q.push_back({1'b0, last_exp});
                end else begin
                    ex_kind = (nb == 8) ? 2 : 3;
                    ex_lat = (nb == 8) ? 2 : 3;
                    ex_wword = mdl_store(ref_mem[ex_idx], off, nb, req_wdata);
                    last_exp = ex_wword;
                    exp_q.push_back({1'b0, 64'h0});
                end
                busy = 1'b1;
                t0 = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic scramble();
        req_write = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_address = $urandom;
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic present(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [63:0] d);
        int n;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_address = a; req_wdata = d;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 10) begin @(negedge clock); n++; end
        if (!req_ready) check("ready_timeout", 64'h0, 64'h1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        scramble();
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [63:0] d);
        int n;
        logic got;
        present(w, sz, sg, a, d);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clock);
            if (resp_valid) got = 1'b1;
            n++;
        end
        #1;
        if (!got) check("resp_timeout", 64'h0, 64'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb;
        logic [31:0] a;
        // Reset with a request pending.
        reset_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_address = 32'h10;
        req_wdata = 64'h1234;
        repeat (3) @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Doubleword store / load.
        send(1'b1, 2'b11, 1'b0, 32'h10, 64'hAAAA_BBBB_CCCC_DDDD);
        check("dw_store_mwd", last_mwd, 64'hAAAA_BBBB_CCCC_DDDD);
        send(1'b0, 2'b11, 1'b0, 32'h10, 64'h0);
        check("dw_load", last_rdata, 64'hAAAA_BBBB_CCCC_DDDD);

        // Byte store through read-modify-write.
        send(1'b1, 2'b00, 1'b0, 32'h13, 64'h80);
        check("rmw_mwd", last_mwd, 64'hAAAA_BBBB_80CC_DDDD);
        check("rmw_model", last_exp, 64'hAAAA_BBBB_80CC_DDDD);
        send(1'b0, 2'b00, 1'b1, 32'h13, 64'h0);
        check("ld_b_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("ld_b_signed_model", last_exp, 64'hFFFF_FFFF_FFFF_FF80);
        send(1'b0, 2'b00, 1'b0, 32'h13, 64'h0);
        check("ld_b_unsigned", last_rdata, 64'h80);

        // Sub-word loads.
        send(1'b0, 2'b01, 1'b1, 32'h16, 64'h0);
        check("ld_h_signed", last_rdata, 64'hFFFF_FFFF_FFFF_AAAA);
        send(1'b0, 2'b10, 1'b0, 32'h14, 64'h0);
        check("ld_w_unsigned", last_rdata, 64'h0000_0000_AAAA_BBBB);
        check("ld_w_unsigned_model", last_exp, 64'h0000_0000_AAAA_BBBB);
        send(1'b0, 2'b10, 1'b1, 32'h10, 64'h0);
        check("ld_w_signed", last_rdata, 64'hFFFF_FFFF_80CC_DDDD);

        // Misaligned requests.
        send(1'b0, 2'b10, 1'b0, 32'h12, 64'h0);
        check("mis_ld_err", {63'h0, last_err}, 64'h1);
        check("mis_ld_rdata", last_rdata, 64'h0);
        send(1'b1, 2'b01, 1'b0, 32'h11, 64'hFFFF);
        check("mis_st_err", {63'h0, last_err}, 64'h1);
        check("mis_st_mem", mem[2], 64'hAAAA_BBBB_80CC_DDDD);

        // Reset during the READ cycle of an RMW store.
        present(1'b1, 2'b00, 1'b0, 32'h10, 64'h55);
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("abort_ready", {63'h0, req_ready}, 64'h1);
        send(1'b0, 2'b11, 1'b0, 32'h10, 64'h0);
        check("abort_mem", last_rdata, 64'hAAAA_BBBB_80CC_DDDD);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            nb = 1 << 0;
            req_size = 2'($urandom_range(0, 3));
            nb = 1 << req_size;
            a = $urandom_range(0, 127);
            if ($urandom_range(0, 3) != 0) a = a & ~(nb - 1);
            send(1'($urandom_range(0, 1)), req_size, 1'($urandom_range(0, 1)), a,
                 {$urandom, $urandom});
        end

        repeat (3) @(posedge clock);
        for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
